// File: rtl/fmul_share_ctrl.sv
// Arbitrates two requesters onto one shared combinational FP multiplier.
// One operation in flight; the result is held until its owner takes it.
module fmul_share_ctrl #(
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [1:0]  req0_rm,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [1:0]  req1_rm,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_s,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_s,
    output logic [31:0] fm_a,
    output logic [31:0] fm_b,
    output logic [1:0]  fm_rm,
    input  logic [31:0] fm_s,
    output logic        busy
);

    // state | meaning
    // IDLE  | waiting for a request; grants one requester
    // BUSY  | operands on the multiplier, counting down settle time
    // DONE  | result held for the owner until it is taken
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES - 1);

    state_t      state, state_nx;
    logic        last;
    logic        owner;
    logic [3:0]  cnt;
    logic [31:0] a_q, b_q, res_q;
    logic [1:0]  rm_q;
    logic        grant1;
    logic        accept;
    logic        take;

    // With both valid, requester 1 wins only if requester 0 was served last.
    assign grant1     = req1_valid & (~req0_valid | ~last);
    assign req0_ready = clrn & (state == IDLE) & req0_valid & ~grant1;
    assign req1_ready = clrn & (state == IDLE) & grant1;
    assign accept     = req0_ready | req1_ready;
    assign take       = (state == DONE) & (owner ? rsp1_ready : rsp0_ready);

    assign rsp0_valid = (state == DONE) & ~owner;
    assign rsp1_valid = (state == DONE) & owner;
    assign rsp0_s     = res_q;
    assign rsp1_s     = res_q;
    assign fm_a       = a_q;
    assign fm_b       = b_q;
    assign fm_rm      = rm_q;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = BUSY;
            BUSY: if (cnt == 4'd0) state_nx = DONE;
            DONE: if (take) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            last  <= 1'b1;
            owner <= 1'b0;
            cnt   <= 4'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            rm_q  <= 2'd0;
            res_q <= 32'd0;
        end else begin
            if (accept) begin
                owner <= grant1;
                a_q   <= grant1 ? req1_a : req0_a;
                b_q   <= grant1 ? req1_b : req0_b;
                rm_q  <= grant1 ? req1_rm : req0_rm;
                cnt   <= CNT_LOAD;
            end
            if (state == BUSY) begin
                if (cnt == 4'd0) res_q <= fm_s;
                else             cnt   <= cnt - 4'd1;
            end
            if (take) last <= owner;
        end
    end

endmodule

// File: doc/fmul_share_ctrl.md
FMUL_SHARE_CTRL -- requirements
Module: fmul_share_ctrl

Interface
REQ-001 Parameter: MUL_CYCLES, default 2, number of cycles the shared combinational multiplier is given to settle (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 clrn  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 presents an operation.
REQ-005 req0_ready  output  1  controller accepts requester 0 operation this cycle.
REQ-006 req0_a, req0_b  input  32 each  IEEE-754 single operands, requester 0.
REQ-007 req0_rm  input  2  rounding mode, requester 0 (00 nearest-even, 01 toward -inf, 10 toward +inf, 11 toward zero).
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_rm  same widths and meaning for requester 1.
REQ-009 rsp0_valid  output  1  result for requester 0 available.
REQ-010 rsp0_ready  input  1  requester 0 takes result.
REQ-011 rsp0_s  output  32  product for requester 0.
REQ-012 rsp1_valid, rsp1_ready, rsp1_s  same for requester 1.
REQ-013 fm_a, fm_b  output  32 each; fm_rm  output  2  operands to shared multiplier.
REQ-014 fm_s  input  32  multiplier product (combinational from fm_a/fm_b/fm_rm).
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-017 In IDLE, grant SHALL go to the single valid requester; if both valid, to the requester not granted last (round-robin pointer).
REQ-018 reqN_ready SHALL be high only in IDLE and only for the granted requester; ready may depend on valid, valid never on ready.
REQ-019 On accept (valid & ready edge), operands, rm and owner id SHALL be registered, counter loaded with MUL_CYCLES-1, state -> BUSY.
REQ-020 fm_a/fm_b/fm_rm SHALL be driven solely from the operand registers (stable throughout BUSY; hold last values in IDLE/DONE).
REQ-021 In BUSY, counter decrements each cycle; on the cycle counter = 0, fm_s SHALL be captured into the result register and state -> DONE.
REQ-022 Latency: rspN_valid SHALL first be high exactly MUL_CYCLES cycles after the accepting edge; MUL_CYCLES=1 gives one cycle.
REQ-023 In DONE, only the owner's rspN_valid SHALL be high, rspN_s = result register; other rsp_valid low.
REQ-024 rspN_valid and rspN_s SHALL hold unchanged until rspN_ready is high; on that edge state -> IDLE and pointer records owner as last granted.
REQ-025 No new request SHALL be accepted in BUSY or DONE (both req_ready low); at most one operation in flight.
REQ-026 rspN_s SHALL equal fm_s bit-exactly (NaN, inf, denormal, overflow results passed through unmodified).
REQ-027 rsp_ready for a requester not owning the DONE result SHALL be ignored.
REQ-028 Counter SHALL be 4 bits; no wrap occurs for legal MUL_CYCLES.

Reset
REQ-029 clrn low SHALL immediately force: state IDLE, pointer so requester 0 has priority next, counter 0, operand/result registers 0, all req_ready/rsp_valid/busy 0, fm_a/fm_b/fm_rm/rsp_s 0.
REQ-030 Reset during BUSY or DONE SHALL abort the operation; no response is ever issued for it.
REQ-031 After clrn deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-032 Single op, MUL_CYCLES=2: req0 a=0x3FC00000 b=0x40000000 rm=00 -> accepted, rsp0_valid 2 cycles later, rsp0_s=0x40400000, rsp1_valid stays 0.
REQ-033 Simultaneous: both valid after reset, req1 a=0x40000000 b=0x40400000 -> req0 served first, then req1 gets rsp1_s=0x40C00000; next simultaneous pair served req1... alternation verified over 4 rounds.
REQ-034 Backpressure: rsp0_ready held low 5 cycles in DONE -> rsp0_valid/rsp0_s stable, req_ready both 0, busy 1; ready high -> IDLE next cycle.
REQ-035 Reset mid-op: clrn pulsed low during BUSY -> all outputs 0 asynchronously, no rsp_valid afterwards; new req0 completes normally.
REQ-036 Specials, MUL_CYCLES=1: a=0x7F800000 b=0x00000000 -> rsp_s NaN (exp 0xFF, frac nonzero) one cycle after accept; a=0x7F000000 b=0x7F000000 rm=11 -> 0x7F7FFFFF.
